// File: rtl/cache_control.sv
// Miss/hit sequencer for the direct-mapped write-back L1: hits complete in the request cycle,
// misses take an optional writeback then a fill; waits on pmem_resp with no timeout, CPU holds its request.
module cache_control #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             mem_read,
   input  logic             mem_write,
   input  logic             tag_match,
   input  logic             valid,
   input  logic             dirty,
   input  logic             pmem_resp,
   output logic             mem_resp,
   output logic             pmem_read,
   output logic             pmem_write,
   output logic             pmem_addr_sel,
   output logic             load_data,
   output logic             data_sel,
   output logic             load_tag,
   output logic             load_valid,
   output logic             load_dirty,
   output logic             dirty_in,
   output logic [CNT_W-1:0] hit_count,
   output logic [CNT_W-1:0] miss_count
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      ALLOCATE  = 2'd2
   } state_t;

   state_t state, state_nxt;
   logic   req, hit, hit_inc, miss_inc;

   assign req = mem_read | mem_write;
   assign hit = tag_match & valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      mem_resp      = 1'b0;
      pmem_read     = 1'b0;
      pmem_write    = 1'b0;
      pmem_addr_sel = 1'b0;
      load_data     = 1'b0;
      data_sel      = 1'b0;
      load_tag      = 1'b0;
      load_valid    = 1'b0;
      load_dirty    = 1'b0;
      dirty_in      = 1'b0;
      hit_inc       = 1'b0;
      miss_inc      = 1'b0;
      case (state)
         IDLE: begin
            if (req && hit) begin
               mem_resp = 1'b1;
               hit_inc  = 1'b1;
               if (mem_write) begin
                  load_data  = 1'b1;
                  load_dirty = 1'b1;
                  dirty_in   = 1'b1;
               end
            end else if (req) begin
               miss_inc  = 1'b1;
               state_nxt = (valid && dirty) ? WRITEBACK : ALLOCATE;
            end
         end
         WRITEBACK: begin
            pmem_write    = 1'b1;
            pmem_addr_sel = 1'b1;
            if (pmem_resp) state_nxt = ALLOCATE;
         end
         ALLOCATE: begin
            pmem_read = 1'b1;
            // Fill lands on this edge; the held request retries as a hit from IDLE.
            if (pmem_resp) begin
               load_data  = 1'b1;
               data_sel   = 1'b1;
               load_tag   = 1'b1;
               load_valid = 1'b1;
               load_dirty = 1'b1;
               state_nxt  = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if (hit_inc && (hit_count != '1))   hit_count  <= hit_count + CNT_W'(1);
         if (miss_inc && (miss_count != '1)) miss_count <= miss_count + CNT_W'(1);
      end
   end

endmodule

// File: doc/cache_control.md
# cache_control

Sequencing controller for the MP3 direct-mapped, write-back L1 cache: 8 sets, 128-bit lines. Owns the write strobes of the cache's data, tag, valid and dirty arrays. Arbitrates each CPU request between a one-cycle hit path and a miss path, where the miss path is an optional writeback followed by a line fill from physical memory. Also keeps saturating hit/miss counters for performance bring-up. It sits between the CPU memory port and the pmem port. The cache datapath (arrays, tag compare, muxes) is a separate block.

## Interface
- CNT_W, 16, width of the hit and miss counters.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- mem_read  in  1  CPU read request, held until mem_resp.
- mem_write  in  1  CPU write request, held until mem_resp. Never asserted together with mem_read.
- tag_match  in  1  indexed tag equals the address tag (combinational from the datapath).
- valid  in  1  valid bit of the indexed set.
- dirty  in  1  dirty bit of the indexed set.
- pmem_resp  in  1  physical memory has completed the current read or write (single-cycle pulse).
- mem_resp  out  1  CPU request is complete this cycle.
- pmem_read  out  1  line-fill request to physical memory.
- pmem_write  out  1  writeback request to physical memory.
- pmem_addr_sel  out  1  1 = {stored tag, index, 4'b0}; 0 = {CPU tag, index, 4'b0}.
- load_data  out  1  data array write strobe.
- data_sel  out  1  data array source: 0 = CPU-merged line, 1 = pmem line.
- load_tag  out  1  tag array write strobe.
- load_valid  out  1  valid array write strobe. The value written is always 1.
- load_dirty  out  1  dirty array write strobe.
- dirty_in  out  1  value written to the dirty array.
- hit_count  out  CNT_W  number of completed hits, saturating.
- miss_count  out  CNT_W  number of misses entered, saturating.

## Operation
- Hit is defined as tag_match & valid. A request is defined as mem_read | mem_write.
- States are IDLE, WRITEBACK and ALLOCATE. Reset places the FSM in IDLE.

IDLE
- Request and hit:
  - Assert mem_resp in the same cycle.
  - On a write, also assert load_data (data_sel=0) and load_dirty with dirty_in=1.
  - hit_count increments by 1.
  - Stay in IDLE.
- Request, miss, and valid & dirty:
  - Go to WRITEBACK.
  - miss_count increments by 1.
- Request, miss, and not (valid & dirty):
  - Go to ALLOCATE.
  - miss_count increments by 1.
- No request: all strobes are 0.

WRITEBACK
- Hold pmem_write=1 and pmem_addr_sel=1.
- On pmem_resp, go to ALLOCATE.
- No array strobes are asserted in this state.

ALLOCATE
- Hold pmem_read=1 and pmem_addr_sel=0.
- On pmem_resp:
  - Assert load_data (data_sel=1), load_tag and load_valid.
  - Assert load_dirty with dirty_in=0.
  - Go to IDLE.
- The request is then served as a hit from IDLE on the next cycle. That hit counts in hit_count, so one miss produces +1 miss and +1 hit.

General rules
- All outputs not explicitly driven above are 0.
- Outputs are a Mealy function of the state and the inputs. State and counters are registered.
- Both counters saturate at 2^CNT_W−1 and do not wrap.

## Timing
- Reset values: state=IDLE, hit_count=0, miss_count=0.
  - All combinational outputs evaluate to 0 in IDLE when there is no request.
- Hit latency: mem_resp arrives in the cycle the request is first seen (0 extra cycles).
- Clean miss latency:
  - Request cycle (IDLE).
  - ALLOCATE for N cycles until pmem_resp; array strobes fire in the pmem_resp cycle.
  - One IDLE hit cycle with mem_resp.
  - mem_resp therefore lands N+1 cycles after the request cycle.
- Dirty miss latency: add the WRITEBACK cycles (M cycles through pmem_resp) before ALLOCATE.
- pmem handshake:
  - pmem_read/pmem_write rise in the first cycle of their state and stay high through the pmem_resp cycle.
  - They drop in the following cycle.
  - They are never high together.
- pmem_resp asserted while in IDLE is ignored.
- Request dropped during WRITEBACK or ALLOCATE: the controller finishes the transaction and the line fill anyway, then returns to IDLE with no mem_resp.
- Arrays write on the rising edge of clk. The controller relies on the combinational array read to see the new line in the cycle after the fill.
- Reset asserted mid-WRITEBACK or mid-ALLOCATE:
  - FSM returns to IDLE and all pmem strobes drop immediately.
  - Partial lines are never written, because strobes are combinational from state.
- Valid array contents are not cleared by this block.

## Test plan
- Read hit: set tag_match=1, valid=1, mem_read=1.
  - Expect mem_resp=1 in the same cycle with all strobes 0.
  - Expect hit_count 0→1.
- Write hit on a clean line: set mem_write=1, tag_match=1, valid=1, dirty=0.
  - Expect mem_resp, load_data with data_sel=0, and load_dirty with dirty_in=1, all in one cycle.
- Clean miss with pmem_resp after 3 cycles:
  - Expect pmem_read high for 3 cycles and the fill strobes (load_data with data_sel=1, load_tag, load_valid, load_dirty with dirty_in=0) in the 3rd cycle.
  - Expect mem_resp on the 4th cycle after the request cycle (the datapath model updates tag_match/valid).
  - Expect miss_count=1 and hit_count=1.
- Dirty miss: set valid=1, dirty=1, tag_match=0, with writeback pmem_resp after 2 cycles and fill pmem_resp after 2 cycles.
  - Expect pmem_write with pmem_addr_sel=1 for 2 cycles, then pmem_read for 2 cycles.
  - Expect pmem_read and pmem_write never high in the same cycle.
- Reset mid-ALLOCATE: pull rst_n low.
  - Expect pmem_read=0 and both counters=0 asynchronously.
  - After release with no request, all outputs are 0.
- Saturation with CNT_W=2: run 5 consecutive read hits.
  - Expect hit_count to read 1, 2, 3, 3, 3.
